// File: rtl/aes_256_sched_if.sv
// aes_256_sched_if: request, core and response signals of the aes_256 sharing sequencer
interface aes_256_sched_if #(
   parameter int NREQ = 4,
   parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*128-1:0] req_state;
   logic [NREQ*256-1:0] req_key;
   logic [127:0]        core_state;
   logic [255:0]        core_key;
   logic [127:0]        core_out;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [127:0]        rsp_data;
   logic [ID_W-1:0]     rsp_id;
   logic                busy;
   modport slave (
      input  req_valid, req_state, req_key, core_out, rsp_ready,
      output req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id, busy
   );
   modport master (
      output req_valid, req_state, req_key, core_out, rsp_ready,
      input  req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/aes_256_sched.sv
// aes_256_sched: shares one multicycle aes_256 core; round-robin when AES256_SCHED_RR_EN is defined, else fixed priority
module aes_256_sched #(
   parameter int NREQ        = 4,
   parameter int WAIT_CYCLES = 2
) (
   input logic            clk,
   input logic            rst,
   aes_256_sched_if.slave bus
);
   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW   = $clog2(WAIT_CYCLES + 1);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [ID_W-1:0] id_r, g, g_lo, rsp_id_r;
   logic            accept, capture, rsp_valid_r;
   logic [127:0]    sel_state, core_state_r, rsp_data_r;
   logic [255:0]    sel_key, core_key_r;
   always_comb begin
      g_lo = '0;
      for (int i = NREQ - 1; i >= 0; i--) g_lo = bus.req_valid[i] ? ID_W'(i) : g_lo;
   end
`ifdef AES256_SCHED_RR_EN
   logic [ID_W-1:0] last, g_hi;
   logic            hi_found;
   // Prefer the lowest requester above last; otherwise wrap to the lowest overall.
   always_comb begin
      g_hi = '0;
      hi_found = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && i > int'(last)) begin
            g_hi = ID_W'(i);
            hi_found = 1'b1;
         end
      end
      g = hi_found ? g_hi : g_lo;
   end
   always_ff @(posedge clk) last <= rst ? ID_W'(NREQ - 1) : accept ? g : last;
`else
   assign g = g_lo;
`endif
   always_comb begin
      sel_state = '0;
      sel_key = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (g == ID_W'(i)) begin
            sel_state = bus.req_state[128*i +: 128];
            sel_key = bus.req_key[256*i +: 256];
         end
      end
   end
   always_comb begin
      state_nx = state;
      accept = 1'b0;
      capture = 1'b0;
      case (state)
         S_IDLE: begin
            accept = |bus.req_valid;
            state_nx = accept ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            capture = cnt == CW'(1);
            state_nx = capture ? S_RESP : S_WAIT;
         end
         default: state_nx = bus.rsp_ready ? S_IDLE : S_RESP;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt <= '0;
         id_r <= '0;
         core_state_r <= '0;
         core_key_r <= '0;
         rsp_valid_r <= 1'b0;
         rsp_data_r <= '0;
         rsp_id_r <= '0;
      end else begin
         state <= state_nx;
         cnt <= accept ? CW'(WAIT_CYCLES) : (state == S_WAIT) ? cnt - 1'b1 : cnt;
         if (accept) begin
            core_state_r <= sel_state;
            core_key_r <= sel_key;
            id_r <= g;
         end
         if (capture) begin
            rsp_data_r <= bus.core_out;
            rsp_id_r <= id_r;
         end
         rsp_valid_r <= capture | (rsp_valid_r & ~bus.rsp_ready);
      end
   end
   assign bus.req_ready  = (accept && !rst) ? NREQ'(1) << g : '0;
   assign bus.core_state = core_state_r;
   assign bus.core_key   = core_key_r;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_data   = rsp_data_r;
   assign bus.rsp_id     = rsp_id_r;
   assign bus.busy       = state != S_IDLE;
endmodule

// File: tb/tb_aes_256_sched.sv
// tb_aes_256_sched: directed and random transactions against a stand-in core and a transaction-level arbitration model
module tb_aes_256_sched;
   localparam int NREQ = 4;
   localparam int WC   = 2;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   int last_m = NREQ - 1;
   logic [127:0] st [NREQ];
   logic [255:0] ky [NREQ];
   aes_256_sched_if #(.NREQ(NREQ)) bus ();
   aes_256_sched #(.NREQ(NREQ), .WAIT_CYCLES(WC)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // Stand-in core: the real FIPS-197 answer for the known vector, a cheap keyed mix otherwise.
   function automatic logic [127:0] core_f(logic [127:0] s, logic [255:0] k);
      return (s == FIPS_PT && k == FIPS_KEY) ? FIPS_CT : {s[63:0], s[127:64]} ^ k[127:0] ^ ~k[255:128];
   endfunction
   assign bus.core_out = core_f(bus.core_state, bus.core_key);
   for (genvar i = 0; i < NREQ; i++) begin : g_pack
      assign bus.req_state[128*i +: 128] = st[i];
      assign bus.req_key[256*i +: 256]   = ky[i];
   end
   task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic scramble();
      for (int i = 0; i < NREQ; i++) begin
         st[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
         ky[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
   endtask
   function automatic int pick(logic [NREQ-1:0] m);
`ifdef AES256_SCHED_RR_EN
      for (int k = 1; k <= NREQ; k++) if (m[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
`else
      for (int k = 0; k < NREQ; k++) if (m[k]) return k;
`endif
      return 0;
   endfunction
   // One full transaction: accept, WC wait cycles with inputs scrambled, then a response held for stall cycles.
   task automatic txn(logic [NREQ-1:0] m, int stall);
      int g;
      logic [127:0] exp_st, exp_ct;
      logic [255:0] exp_k;
      bus.req_valid = m;
      bus.rsp_ready = (stall == 0);
      #1;
      g = pick(m);
      check("idle_busy", bus.busy, 0);
      check("grant", bus.req_ready, 1 << g);
      exp_st = st[g];
      exp_k = ky[g];
      exp_ct = core_f(st[g], ky[g]);
      last_m = g;
      tick();
      scramble();
      for (int c = 0; c < WC; c++) begin
         check("wait_busy", bus.busy, 1);
         check("wait_ready", bus.req_ready, 0);
         check("wait_rsp_valid", bus.rsp_valid, 0);
         check("core_state", bus.core_state, exp_st);
         check("core_key", bus.core_key, exp_k);
         tick();
      end
      for (int s = 0; s <= stall; s++) begin
         if (s == stall) bus.rsp_ready = 1'b1;
         check("rsp_valid", bus.rsp_valid, 1);
         check("rsp_data", bus.rsp_data, exp_ct);
         check("rsp_id", bus.rsp_id, g);
         check("resp_ready", bus.req_ready, 0);
         check("resp_busy", bus.busy, 1);
         tick();
      end
      check("rsp_done", bus.rsp_valid, 0);
      check("idle_after", bus.busy, 0);
   endtask
   initial begin
      logic [NREQ-1:0] m;
      scramble();
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      repeat (3) tick();
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_core_state", bus.core_state, 0);
      check("rst_core_key", bus.core_key, 0);
      rst = 1'b0;
      bus.req_valid = '0;
      tick();
      check("noreq_ready", bus.req_ready, 0);
      check("noreq_busy", bus.busy, 0);
      st[2] = FIPS_PT;
      ky[2] = FIPS_KEY;
      txn(4'b0100, 0);
      repeat (5) txn('1, 0);
      txn('1, 10);
      txn(4'b1010, 0);
      repeat (20) begin
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         txn(m, $urandom_range(0, 3));
      end
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b1;
      #1;
      check("pre_reset_grant", bus.req_ready, 1 << pick(4'b0010));
      tick();
      check("pre_reset_busy", bus.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_m = NREQ - 1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_rsp_valid", bus.rsp_valid, 0);
      check("midrst_core_key", bus.core_key, 0);
      check("midrst_core_state", bus.core_state, 0);
      txn(4'b1000, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_m = NREQ - 1;
      txn('1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
